// File: rtl/lora_link_ctrl.sv
// Half-duplex LoRa link sequencer: polls the bicycle node over the UART, waits for a parsed frame,
// retries on timeout/bad frame and flags link loss. Optional stats counters: define LORA_LINK_STATS_EN.
module lora_link_ctrl #(
    parameter int unsigned POLL_CYC    = 50_000_000,
    parameter int unsigned TIMEOUT_CYC = 20_000_000,
    parameter int unsigned MAX_RETRY   = 3,
    parameter logic [7:0]  NODE_ID     = 8'h31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        tx_ready,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        rx_frame_done,
    input  logic        rx_frame_bad,
    output logic        link_ok,
    output logic        link_lost,
    output logic [3:0]  retry_cnt,
    output logic        poll_done,
    output logic [15:0] good_cnt,
    output logic [15:0] fail_cnt,
    output logic [2:0]  state_dbg
);

    // Handshake: tx_start is a one-cycle strobe raised only after tx_ready was sampled high;
    // the UART latches tx_data with it, and tx_ready is not looked at again for one cycle.

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND      = 3'd1,
        HOLD      = 3'd2,
        WAIT_RESP = 3'd3,
        GAP       = 3'd4
    } state_t;

    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYC - 1);
    localparam logic [31:0] GAP_LAST  = 32'(POLL_CYC - 1);
    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

    state_t      state, state_n;
    logic [1:0]  idx, idx_n;
    logic [31:0] timer, timer_n;
    logic        tx_start_n;
    logic [7:0]  tx_data_n;
    logic        link_ok_n, link_lost_n, poll_done_n;
    logic [3:0]  retry_n;
    logic [3:0]  retry_inc;

    assign retry_inc = retry_cnt + 4'd1;
    assign state_dbg = state;

    function automatic logic [7:0] poll_byte(input logic [1:0] i);
        case (i)
            2'd0:    poll_byte = 8'h24;
            2'd1:    poll_byte = 8'h51;
            default: poll_byte = NODE_ID;
        endcase
    endfunction

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        timer_n     = timer;
        tx_start_n  = 1'b0;
        tx_data_n   = tx_data;
        link_ok_n   = link_ok;
        link_lost_n = link_lost;
        retry_n     = retry_cnt;
        poll_done_n = 1'b0;
        if (!en) begin
            state_n = IDLE;
            timer_n = '0;
            idx_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = SEND;
                    idx_n   = '0;
                    timer_n = '0;
                end
                SEND: begin
                    if (tx_ready) begin
                        tx_start_n = 1'b1;
                        tx_data_n  = poll_byte(idx);
                        state_n    = HOLD;
                        timer_n    = '0;
                    end
                end
                HOLD: begin
                    // timer==0 marks the blind cycle in which the UART drops tx_ready
                    if (timer == 32'd0) begin
                        timer_n = 32'd1;
                    end else if (tx_ready) begin
                        timer_n = '0;
                        if (idx < 2'd2) begin
                            idx_n   = idx + 2'd1;
                            state_n = SEND;
                        end else begin
                            state_n = WAIT_RESP;
                        end
                    end
                end
                WAIT_RESP: begin
                    if (rx_frame_done) begin
                        link_ok_n   = 1'b1;
                        link_lost_n = 1'b0;
                        retry_n     = '0;
                        poll_done_n = 1'b1;
                        state_n     = GAP;
                        timer_n     = '0;
                    end else if (rx_frame_bad || timer == TMO_LAST) begin
                        link_ok_n = 1'b0;
                        timer_n   = '0;
                        if (retry_inc == RETRY_MAX) begin
                            link_lost_n = 1'b1;
                            poll_done_n = 1'b1;
                            retry_n     = '0;
                            state_n     = GAP;
                        end else begin
                            retry_n = retry_inc;
                            idx_n   = '0;
                            state_n = SEND;
                        end
                    end else begin
                        timer_n = timer + 32'd1;
                    end
                end
                GAP: begin
                    if (timer == GAP_LAST) begin
                        state_n = SEND;
                        idx_n   = '0;
                        timer_n = '0;
                    end else begin
                        timer_n = timer + 32'd1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    timer_n = '0;
                    idx_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            timer     <= '0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            link_ok   <= 1'b0;
            link_lost <= 1'b0;
            retry_cnt <= '0;
            poll_done <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            timer     <= timer_n;
            tx_start  <= tx_start_n;
            tx_data   <= tx_data_n;
            link_ok   <= link_ok_n;
            link_lost <= link_lost_n;
            retry_cnt <= retry_n;
            poll_done <= poll_done_n;
        end
    end

`ifdef LORA_LINK_STATS_EN
    logic        timeout_hit;
    logic        bad_hit;
    logic [16:0] fail_sum;

    // A good frame masks a coincident timeout or bad frame
    assign timeout_hit = en && (state == WAIT_RESP) && !rx_frame_done && (timer == TMO_LAST);
    assign bad_hit     = rx_frame_bad && !rx_frame_done;
    assign fail_sum    = {1'b0, fail_cnt} + {16'd0, timeout_hit} + {16'd0, bad_hit};

    always_ff @(posedge clk) begin
        if (rst) begin
            good_cnt <= '0;
            fail_cnt <= '0;
        end else begin
            if (rx_frame_done && good_cnt != 16'hFFFF)
                good_cnt <= good_cnt + 16'd1;
            fail_cnt <= fail_sum[16] ? 16'hFFFF : fail_sum[15:0];
        end
    end
`else
    assign good_cnt = '0;
    assign fail_cnt = '0;
`endif

endmodule

// File: tb/tb_lora_link_ctrl.sv
// Directed bench for lora_link_ctrl: a cycle-level behavioural model of the poll protocol checked
// every cycle, a tx byte scoreboard, and hand-computed literal expectations for each scenario.
module tb_lora_link_ctrl;

    localparam int TO   = 50;
    localparam int POLL = 100;
    localparam int MAXR = 3;

    logic        clk = 1'b0;
    logic        rst, en, rx_frame_done, rx_frame_bad;
    logic        tx_ready = 1'b1;
    logic        tx_start, link_ok, link_lost, poll_done;
    logic [7:0]  tx_data;
    logic [3:0]  retry_cnt;
    logic [15:0] good_cnt, fail_cnt;
    logic [2:0]  state_dbg;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    lora_link_ctrl #(
        .POLL_CYC(POLL), .TIMEOUT_CYC(TO), .MAX_RETRY(MAXR), .NODE_ID(8'h31)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .tx_ready(tx_ready),
        .tx_start(tx_start), .tx_data(tx_data),
        .rx_frame_done(rx_frame_done), .rx_frame_bad(rx_frame_bad),
        .link_ok(link_ok), .link_lost(link_lost), .retry_cnt(retry_cnt),
        .poll_done(poll_done), .good_cnt(good_cnt), .fail_cnt(fail_cnt),
        .state_dbg(state_dbg)
    );

    // ---------------- behavioural model ----------------
    // Phases: off, polling (issuing bytes), listening (response window), resting (poll interval).
    localparam int P_OFF = 0, P_POLL = 1, P_LISTEN = 2, P_REST = 3;
    int   m_phase = P_OFF;
    int   m_k, m_need, m_since, m_age;
    bit   model_valid = 1'b0;
    logic       e_start, e_ok, e_lost, e_pd;
    logic [7:0] e_data;
    logic [3:0] e_retry;
    logic [15:0] e_good, e_fail;

    function automatic logic [7:0] msg_byte(input int k);
        logic [7:0] msg [3];
        msg[0] = 8'h24; msg[1] = 8'h51; msg[2] = 8'h31;
        return msg[k];
    endfunction

    // A poll needs one usable tx_ready edge for its first byte; every later byte needs two
    // (UART free again, then issue); after the last byte one more usable edge opens the window.
    task automatic begin_poll();
        m_phase = P_POLL; m_k = 0; m_need = 1; m_since = 2;
    endtask

    always @(posedge clk) begin
        e_start = 1'b0;
        e_pd    = 1'b0;
        if (rst) begin
            model_valid = 1'b1;
            m_phase = P_OFF;
            e_data = 8'h00; e_ok = 1'b0; e_lost = 1'b0; e_retry = 4'd0;
            e_good = 16'd0; e_fail = 16'd0;
        end else begin
`ifdef LORA_LINK_STATS_EN
            if (rx_frame_done && e_good != 16'hFFFF) e_good = e_good + 16'd1;
            if (rx_frame_bad && !rx_frame_done && e_fail != 16'hFFFF) e_fail = e_fail + 16'd1;
            if (en && m_phase == P_LISTEN && !rx_frame_done && m_age == TO - 1 && e_fail != 16'hFFFF)
                e_fail = e_fail + 16'd1;
`endif
            if (!en) begin
                m_phase = P_OFF;
            end else if (m_phase == P_OFF) begin
                begin_poll();
            end else if (m_phase == P_POLL) begin
                if (m_since < 2) m_since++;
                if (m_since >= 2 && tx_ready) m_need--;
                if (m_need == 0) begin
                    if (m_k < 3) begin
                        e_start = 1'b1;
                        e_data  = msg_byte(m_k);
                        m_k++;
                        m_since = 0;
                        m_need  = (m_k < 3) ? 2 : 1;
                    end else begin
                        m_phase = P_LISTEN;
                        m_age   = 0;
                    end
                end
            end else if (m_phase == P_LISTEN) begin
                if (rx_frame_done) begin
                    e_ok = 1'b1; e_lost = 1'b0; e_retry = 4'd0; e_pd = 1'b1;
                    m_phase = P_REST; m_age = 0;
                end else if (rx_frame_bad || m_age == TO - 1) begin
                    e_ok = 1'b0;
                    if (int'(e_retry) + 1 == MAXR) begin
                        e_lost = 1'b1; e_pd = 1'b1; e_retry = 4'd0;
                        m_phase = P_REST; m_age = 0;
                    end else begin
                        e_retry = e_retry + 4'd1;
                        begin_poll();
                    end
                end else begin
                    m_age++;
                end
            end else begin
                if (m_age == POLL - 1) begin_poll();
                else m_age++;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_valid) begin
            n_vec++;
            if ({tx_start, tx_data, link_ok, link_lost, retry_cnt, poll_done, good_cnt, fail_cnt} !==
                {e_start, e_data, e_ok, e_lost, e_retry, e_pd, e_good, e_fail}) begin
                n_err++;
                $display("FAIL cycle_cmp t=%0t got start=%b data=%h ok=%b lost=%b retry=%0d pd=%b good=%0d fail=%0d, want start=%b data=%h ok=%b lost=%b retry=%0d pd=%b good=%0d fail=%0d",
                         $time, tx_start, tx_data, link_ok, link_lost, retry_cnt, poll_done, good_cnt, fail_cnt,
                         e_start, e_data, e_ok, e_lost, e_retry, e_pd, e_good, e_fail);
            end
        end
    end

    // ---------------- UART model + byte scoreboard ----------------
    int busy = 0;
    always @(negedge clk) begin
        if (model_valid && !rst && tx_start === 1'b1) begin
            n_vec++;
            if (tx_ready !== 1'b1) begin
                n_err++;
                $display("FAIL start_while_busy: tx_start=1 with tx_ready=%b, want tx_ready=1", tx_ready);
            end
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_extra: tx_data=%h, want no byte", tx_data);
            end else begin
                logic [7:0] want;
                want = exp_q.pop_front();
                if (tx_data !== want) begin
                    n_err++;
                    $display("FAIL sb_byte: tx_data=%h, want %h", tx_data, want);
                end
            end
            tx_ready = 1'b0;
            busy = 10;
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) tx_ready = 1'b1;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, want);
        end
    endtask

    task automatic expect_poll();
        exp_q.push_back(8'h24);
        exp_q.push_back(8'h51);
        exp_q.push_back(8'h31);
    endtask

    task automatic wait_start(input string name, output int cyc);
        cyc = -1;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                cyc = i;
                return;
            end
        end
        n_vec++;
        n_err++;
        $display("FAIL %s: no tx_start within 400 cycles, want one", name);
    endtask

    task automatic pulse(input bit done, input bit bad);
        rx_frame_done = done;
        rx_frame_bad  = bad;
        @(negedge clk);
        rx_frame_done = 1'b0;
        rx_frame_bad  = 1'b0;
    endtask

    task automatic three_bytes(input string name);
        int w;
        for (int b = 0; b < 3; b++) wait_start(name, w);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int w, cnt;
        rst = 1'b1; en = 1'b0; rx_frame_done = 1'b0; rx_frame_bad = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {tx_start, tx_data, link_ok, link_lost, retry_cnt, poll_done, good_cnt, fail_cnt}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: first poll is immediate, three bytes paced by the UART
        en = 1'b1;
        expect_poll();
        wait_start("t1_first", w);
        chk("t1_first_latency", w, 2);
        wait_start("t1_b1", w);
        chk("t1_byte_spacing", w, 12);
        wait_start("t1_b2", w);

        // 2: good frame 20 cycles after the last byte
        repeat (20) @(negedge clk);
        pulse(1'b1, 1'b0);
        chk("t2_status", {link_ok, link_lost, retry_cnt, poll_done}, {1'b1, 1'b0, 4'd0, 1'b1});
        expect_poll();
        wait_start("t2_next", w);
        chk("t2_gap", w, 101);
        wait_start("t2_b1", w);
        wait_start("t2_b2", w);

        // 3: three silent polls -> link lost, then a good frame recovers
        for (int r = 1; r <= 3; r++) begin
            repeat (61) @(negedge clk);
            chk("t3_retry", retry_cnt, (r == 3) ? 0 : r);
            chk("t3_flags", {link_ok, link_lost, poll_done}, (r == 3) ? 3'b011 : 3'b000);
            expect_poll();
            wait_start("t3_repoll", w);
            chk("t3_repoll_gap", w, (r == 3) ? 101 : 1);
            wait_start("t3_b1", w);
            wait_start("t3_b2", w);
        end
        repeat (20) @(negedge clk);
        pulse(1'b1, 1'b0);
        chk("t3_recover", {link_ok, link_lost, retry_cnt}, {1'b1, 1'b0, 4'd0});

        // 4: bad frame in the response window -> immediate re-poll
        expect_poll();
        three_bytes("t4_poll");
        repeat (15) @(negedge clk);
        pulse(1'b0, 1'b1);
        chk("t4_retry", {link_ok, retry_cnt}, {1'b0, 4'd1});
`ifdef LORA_LINK_STATS_EN
        chk("t4_fail_cnt", fail_cnt, 4);
`endif
        expect_poll();
        wait_start("t4_repoll", w);
        chk("t4_repoll_latency", w, 1);
        wait_start("t4_b1", w);
        wait_start("t4_b2", w);

        // 5: good frame on the very cycle of the timeout wins
        repeat (60) @(negedge clk);
        pulse(1'b1, 1'b0);
        chk("t5_good_wins", {link_ok, retry_cnt, poll_done}, {1'b1, 4'd0, 1'b1});
        repeat (10) @(negedge clk);
        pulse(1'b0, 1'b1);
        chk("t5_bad_in_gap", {link_ok, retry_cnt}, {1'b1, 4'd0});
        pulse(1'b1, 1'b0);

        // 6: drop en while the last byte is in flight, then restart
        expect_poll();
        three_bytes("t6_poll");
        repeat (3) @(negedge clk);
        en = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx_start === 1'b1) cnt++;
        end
        chk("t6_no_start", cnt, 0);
        chk("t6_status_held", {link_ok, link_lost, retry_cnt}, {1'b1, 1'b0, 4'd0});
        en = 1'b1;
        expect_poll();
        wait_start("t6_restart", w);
        chk("t6_restart_byte", tx_data, 8'h24);
        wait_start("t6_b1", w);
        wait_start("t6_b2", w);
        repeat (15) @(negedge clk);
        pulse(1'b1, 1'b1);
        chk("t6_done_and_bad", {link_ok, retry_cnt, poll_done}, {1'b1, 4'd0, 1'b1});

        // 7: reset in the middle of an exchange
        expect_poll();
        three_bytes("t7_poll");
        repeat (5) @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        chk("t7_reset_outputs", {tx_start, tx_data, link_ok, link_lost, retry_cnt, poll_done, good_cnt, fail_cnt}, 64'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

endmodule
